hazard_ctrl: RTL



---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hazard_scoreboard.sv | 37 +++
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: scoreboard record layout, forwarding
// select encoding, PC-write FSM states and the register-match helper.
package hazard_pkg;

  localparam logic [3:0] PC_REG = 4'd15;
  localparam int         REC_W  = 6;

  typedef struct packed {
    logic       valid;
    logic [3:0] wa;
    logic       ld;
  } stage_rec_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    PCW  = 1'b1
  } pcw_state_t;

  // The PC is never a scoreboard dependency, on either side of the compare.
  function automatic logic rec_hit(stage_rec_t rec, logic [3:0] ra);
    return rec.valid && (rec.wa != PC_REG) && (ra != PC_REG) && (rec.wa == ra);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination records for the E, M and W stages. E captures the D
// instruction (dropped when D/E is flushed); M and W always advance.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_reg_write,
  input  logic [3:0]       i_wa,
  input  logic             i_ld,
  input  logic             i_flush,
  output logic [REC_W-1:0] o_rec_e,
  output logic [REC_W-1:0] o_rec_m,
  output logic [REC_W-1:0] o_rec_w
);

  stage_rec_t r_rec_e;
  stage_rec_t r_rec_m;
  stage_rec_t r_rec_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rec_e <= '0;
      r_rec_m <= '0;
      r_rec_w <= '0;
    end else begin
      r_rec_e <= stage_rec_t'{valid: i_reg_write & ~i_flush, wa: i_wa, ld: i_ld};
      r_rec_m <= r_rec_e;
      r_rec_w <= r_rec_m;
    end
  end

  assign o_rec_e = r_rec_e;
  assign o_rec_m = r_rec_m;
  assign o_rec_w = r_rec_w;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline. Define
// HAZARD_FORWARDING_EN for forwarding + load-use stalls; otherwise full RAW stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RBITS   = 4,
  parameter int PCW_LAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RBITS-1:0] RA1D,
  input  logic [RBITS-1:0] RA2D,
  input  logic [RBITS-1:0] WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcD,
  input  logic [RBITS-1:0] RA1E,
  input  logic [RBITS-1:0] RA2E,
  input  logic             BranchTakenE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE
);

  logic [REC_W-1:0] w_rec_e_bits;
  logic [REC_W-1:0] w_rec_m_bits;
  logic [REC_W-1:0] w_rec_w_bits;
  stage_rec_t       w_rec_e;
  stage_rec_t       w_rec_m;
  stage_rec_t       w_rec_w;
  logic [3:0]       w_ra1d;
  logic [3:0]       w_ra2d;
  logic [3:0]       w_ra1e;
  logic [3:0]       w_ra2e;
  logic             w_stall;
  logic             w_flush_e;
  logic             w_in_pcw;
  fwd_sel_t         w_fwd_a;
  fwd_sel_t         w_fwd_b;
  pcw_state_t       r_state;
  logic [2:0]       r_cnt;

  assign w_ra1d  = 4'(RA1D);
  assign w_ra2d  = 4'(RA2D);
  assign w_ra1e  = 4'(RA1E);
  assign w_ra2e  = 4'(RA2E);
  assign w_rec_e = stage_rec_t'(w_rec_e_bits);
  assign w_rec_m = stage_rec_t'(w_rec_m_bits);
  assign w_rec_w = stage_rec_t'(w_rec_w_bits);

  hazard_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .i_reg_write (RegWriteD),
    .i_wa        (4'(WA3D)),
    .i_ld        (MemtoRegD),
    .i_flush     (w_flush_e),
    .o_rec_e     (w_rec_e_bits),
    .o_rec_m     (w_rec_m_bits),
    .o_rec_w     (w_rec_w_bits)
  );

`ifdef HAZARD_FORWARDING_EN
  // Only a load in E cannot be forwarded in time; everything else bypasses.
  assign w_stall = w_rec_e.ld & (rec_hit(w_rec_e, w_ra1d) | rec_hit(w_rec_e, w_ra2d));
  assign w_fwd_a = rec_hit(w_rec_m, w_ra1e) ? FWD_MEM :
                   rec_hit(w_rec_w, w_ra1e) ? FWD_WB  : FWD_RF;
  assign w_fwd_b = rec_hit(w_rec_m, w_ra2e) ? FWD_MEM :
                   rec_hit(w_rec_w, w_ra2e) ? FWD_WB  : FWD_RF;
`else
  logic w_unused;
  assign w_unused = ^{w_ra1e, w_ra2e};
  // No bypass network: hold D until every pending writer has retired.
  assign w_stall = rec_hit(w_rec_e, w_ra1d) | rec_hit(w_rec_e, w_ra2d) |
                   rec_hit(w_rec_m, w_ra1d) | rec_hit(w_rec_m, w_ra2d) |
                   rec_hit(w_rec_w, w_ra1d) | rec_hit(w_rec_w, w_ra2d);
  assign w_fwd_a = FWD_RF;
  assign w_fwd_b = FWD_RF;
`endif

  assign w_flush_e = w_stall | BranchTakenE;
  assign w_in_pcw  = (r_state == PCW);

  always_ff @(posedge clk) begin
    if (reset || BranchTakenE) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (PCSrcD && !w_stall) begin
            r_state <= PCW;
            r_cnt   <= 3'(PCW_LAT);
          end
        end
        PCW: begin
          if (r_cnt == 3'd1) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign FlushE    = ~reset & w_flush_e;
  assign FlushD    = ~reset & (BranchTakenE | w_in_pcw);
  assign StallD    = ~reset & w_stall & ~BranchTakenE;
  assign StallF    = ~reset & ((w_stall & ~BranchTakenE) | w_in_pcw);
  assign ForwardAE = reset ? FWD_RF : w_fwd_a;
  assign ForwardBE = reset ? FWD_RF : w_fwd_b;

endmodule
